// File: rtl/gear_pkg.sv
// Shared types and constants for the per-player drivetrain model (gear_shift_controller).
package gear_pkg;

    localparam int GEAR_W    = 3;
    localparam int RPM_W     = 14;
    localparam int SPEED_W   = 10;
    localparam int RATE_W    = 9;
    localparam int PEN_W     = 6;
    localparam int NUM_GEARS = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REV     = 2'd1,
        LIMIT   = 2'd2,
        PENALTY = 2'd3
    } state_t;

    localparam logic [GEAR_W-1:0] FIRST_GEAR    = 3'd1;
    localparam logic [GEAR_W-1:0] MAX_GEAR      = 3'd5;
    localparam logic [RPM_W-1:0]  RPM_MAX       = 14'd8000;
    localparam logic [RPM_W-1:0]  IDLE_RPM      = 14'd1000;
    localparam logic [RPM_W-1:0]  SHIFT_LOW     = 14'd6000;
    localparam logic [RPM_W-1:0]  SHIFT_DROP    = 14'd3500;
    localparam logic [RPM_W-1:0]  DECAY         = 14'd50;
    localparam logic [PEN_W-1:0]  PENALTY_TICKS = 6'd32;

    // Index 0 is gear 1: rates 400, 300, 200, 150, 100 rpm per tick.
    localparam logic [NUM_GEARS-1:0][RATE_W-1:0] RATE_TAB =
        {9'd100, 9'd150, 9'd200, 9'd300, 9'd400};

endpackage

// File: rtl/gear_shift_controller_if.sv
// Control/status bundle between the race logic and one gear_shift_controller.
interface gear_shift_controller_if;
    import gear_pkg::*;

    logic                enable;
    logic                restart;
    logic                throttle;
    logic                shift_tick;
    logic [GEAR_W-1:0]   current_gear;
    logic [RPM_W-1:0]    rpm;
    logic                gear_change_status;
    logic [SPEED_W-1:0]  speed;
    logic                limiter_active;

    modport master (
        output enable, restart, throttle, shift_tick,
        input  current_gear, rpm, gear_change_status, speed, limiter_active
    );

    modport slave (
        input  enable, restart, throttle, shift_tick,
        output current_gear, rpm, gear_change_status, speed, limiter_active
    );

endinterface

// File: rtl/gear_rate_lut.sv
// Combinational gear -> rpm rate per tick; gears outside 1..NUM_GEARS give 0.
module gear_rate_lut
    import gear_pkg::*;
(
    input  logic [GEAR_W-1:0] gear,
    output logic [RATE_W-1:0] rate
);

    logic [RATE_W-1:0] term [NUM_GEARS];

    generate
        for (genvar gi = 0; gi < NUM_GEARS; gi++) begin : g_term
            assign term[gi] = (gear == GEAR_W'(gi + 1)) ? RATE_TAB[gi] : '0;
        end
    endgenerate

    // At most one term is non-zero, so an OR-reduction selects it.
    always_comb begin
        rate = '0;
        for (int i = 0; i < NUM_GEARS; i++) begin
            rate = rate | term[i];
        end
    end

endmodule

// File: rtl/gear_shift_controller.sv
// Per-player drivetrain: throttle/shift ticks -> rpm, gear, speed and shift-window flags.
// Optional feature macro AUTO_SHIFT_EN: automatic upshift from LIMIT, early shifts ignored.
module gear_shift_controller
    import gear_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    gear_shift_controller_if.slave  bus
);

    state_t              state_reg, state_next;
    logic [GEAR_W-1:0]   gear_reg, gear_next;
    logic [RPM_W-1:0]    rpm_reg, rpm_next;
    logic [PEN_W-1:0]    pen_reg, pen_next;
    logic                gcs_reg, gcs_next;
    logic                limit_reg, limit_next;
    logic [SPEED_W-1:0]  speed_reg, speed_next;

    logic [RATE_W-1:0]   rate;
    logic [RPM_W:0]      rpm_sum;
    logic [RPM_W-1:0]    rpm_up;
    logic [RPM_W-1:0]    rpm_down;
    logic                gear_top;
    logic                shift_ok;
    logic                shift_early;

    gear_rate_lut u_rate_lut (
        .gear (gear_reg),
        .rate (rate)
    );

    // One extra bit on the sum so the add can never wrap before clamping.
    assign rpm_sum  = {1'b0, rpm_reg} + (RPM_W + 1)'(rate);
    assign rpm_up   = (rpm_sum >= {1'b0, RPM_MAX}) ? RPM_MAX : rpm_sum[RPM_W-1:0];
    assign rpm_down = (rpm_reg >= IDLE_RPM + DECAY) ? rpm_reg - DECAY : IDLE_RPM;
    assign gear_top = (gear_reg == MAX_GEAR);

    // gcs_reg always tracks the current rpm, so it doubles as the shift-window test.
`ifdef AUTO_SHIFT_EN
    assign shift_ok    = !gear_top && (state_reg != PENALTY) &&
                         ((bus.shift_tick && gcs_reg) || (state_reg == LIMIT));
    assign shift_early = 1'b0;
`else
    assign shift_ok    = bus.shift_tick && gcs_reg && !gear_top && (state_reg != PENALTY);
    assign shift_early = bus.shift_tick && !gcs_reg && !gear_top && (state_reg != PENALTY);
`endif

    always_comb begin
        state_next = state_reg;
        gear_next  = gear_reg;
        rpm_next   = rpm_reg;
        pen_next   = pen_reg;
        if (bus.restart) begin
            state_next = IDLE;
            gear_next  = FIRST_GEAR;
            rpm_next   = IDLE_RPM;
            pen_next   = '0;
        end else if (!bus.enable) begin
            state_next = IDLE;
            rpm_next   = rpm_down;
            pen_next   = '0;
        end else if (state_reg == PENALTY) begin
            rpm_next = rpm_down;
            pen_next = pen_reg - 6'd1;
            if (pen_reg == 6'd1) begin
                state_next = REV;
            end
        end else if (shift_ok) begin
            gear_next  = gear_reg + 3'd1;
            rpm_next   = SHIFT_DROP;
            state_next = REV;
        end else if (shift_early) begin
            state_next = PENALTY;
            pen_next   = PENALTY_TICKS;
        end else if (bus.throttle) begin
            rpm_next   = rpm_up;
            state_next = (rpm_up == RPM_MAX) ? LIMIT : REV;
        end else begin
            rpm_next   = rpm_down;
            state_next = REV;
        end
    end

    assign gcs_next   = (rpm_next >= SHIFT_LOW);
    assign limit_next = (state_next == LIMIT);
    assign speed_next = SPEED_W'(rpm_next[RPM_W-1:7]) * SPEED_W'(gear_next);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            gear_reg  <= FIRST_GEAR;
            rpm_reg   <= IDLE_RPM;
            pen_reg   <= '0;
            gcs_reg   <= 1'b0;
            limit_reg <= 1'b0;
            speed_reg <= SPEED_W'(IDLE_RPM[RPM_W-1:7]);
        end else begin
            state_reg <= state_next;
            gear_reg  <= gear_next;
            rpm_reg   <= rpm_next;
            pen_reg   <= pen_next;
            gcs_reg   <= gcs_next;
            limit_reg <= limit_next;
            speed_reg <= speed_next;
        end
    end

    assign bus.current_gear       = gear_reg;
    assign bus.rpm                = rpm_reg;
    assign bus.gear_change_status = gcs_reg;
    assign bus.speed              = speed_reg;
    assign bus.limiter_active     = limit_reg;

endmodule

// File: tb/tb_gear_shift_controller.sv
// Directed bench for gear_shift_controller with a cycle-level behavioural reference model.
module tb_gear_shift_controller;
    import gear_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   cmp_on = 1'b0;

    gear_shift_controller_if bus ();

    gear_shift_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [GEAR_W-1:0] lut_gear;
    logic [RATE_W-1:0] lut_rate;

    gear_rate_lut u_lut (
        .gear (lut_gear),
        .rate (lut_rate)
    );

    always #5 clk = ~clk;

    // Reference model: modes 0=idle 1=rev 2=limit 3=penalty, plain integers throughout.
    int rate_tab [8] = '{0, 400, 300, 200, 150, 100, 0, 0};
    int m_mode = 0;
    int m_gear = 1;
    int m_rpm  = 1000;
    int m_pen  = 0;

    function automatic int decayed(input int r);
        return (r - 50 < 1000) ? 1000 : r - 50;
    endfunction

    task automatic model_start();
        m_mode = 0; m_gear = 1; m_rpm = 1000; m_pen = 0;
    endtask

    task automatic model_step();
        bit auto_up;
`ifdef AUTO_SHIFT_EN
        auto_up = (m_mode == 2);
`else
        auto_up = 1'b0;
`endif
        if (bus.restart) begin
            model_start();
        end else if (!bus.enable) begin
            m_mode = 0; m_rpm = decayed(m_rpm); m_pen = 0;
        end else if (m_mode == 3) begin
            m_rpm = decayed(m_rpm);
            m_pen = m_pen - 1;
            if (m_pen == 0) m_mode = 1;
        end else if (m_gear < 5 && ((bus.shift_tick && m_rpm >= 6000) || auto_up)) begin
            m_gear = m_gear + 1; m_rpm = 3500; m_mode = 1;
`ifndef AUTO_SHIFT_EN
        end else if (bus.shift_tick && m_gear < 5 && m_rpm < 6000) begin
            m_mode = 3; m_pen = 32;
`endif
        end else if (bus.throttle) begin
            m_rpm  = (m_rpm + rate_tab[m_gear] > 8000) ? 8000 : m_rpm + rate_tab[m_gear];
            m_mode = (m_rpm == 8000) ? 2 : 1;
        end else begin
            m_rpm = decayed(m_rpm); m_mode = 1;
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) model_start();
        else        model_step();
    end

    task automatic check(input string name, input int actual, input int expected, input bit quiet);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end else if (!quiet) begin
            $display("check %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Every cycle: DUT outputs against the model.
    always @(negedge clk) begin
        if (cmp_on) begin
            check("cyc_gear",  int'(bus.current_gear),       m_gear, 1'b1);
            check("cyc_rpm",   int'(bus.rpm),                m_rpm, 1'b1);
            check("cyc_gcs",   int'(bus.gear_change_status), int'(m_rpm >= 6000), 1'b1);
            check("cyc_speed", int'(bus.speed),              (m_rpm / 128) * m_gear, 1'b1);
            check("cyc_lim",   int'(bus.limiter_active),     int'(m_mode == 2), 1'b1);
        end
    end

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_shift();
        bus.shift_tick = 1'b1;
        @(negedge clk);
        bus.shift_tick = 1'b0;
    endtask

    task automatic pulse_restart();
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
    endtask

    task automatic check_start(input string tag);
        check({tag, "_gear"},  int'(bus.current_gear),       1,    1'b0);
        check({tag, "_rpm"},   int'(bus.rpm),                1000, 1'b0);
        check({tag, "_gcs"},   int'(bus.gear_change_status), 0,    1'b0);
        check({tag, "_speed"}, int'(bus.speed),              7,    1'b0);
        check({tag, "_lim"},   int'(bus.limiter_active),     0,    1'b0);
    endtask

    // Shift whenever the window is open until the target gear is reached (bounded).
    task automatic climb_to(input int g);
        for (int i = 0; i < 400 && int'(bus.current_gear) != g; i++) begin
            bus.shift_tick = bus.gear_change_status;
            @(negedge clk);
            bus.shift_tick = 1'b0;
        end
        check("climb_gear", int'(bus.current_gear), g, 1'b0);
    endtask

    task automatic ramp_to_limit();
        for (int i = 0; i < 100 && !bus.limiter_active; i++) @(negedge clk);
        check("ramp_lim", int'(bus.limiter_active), 1, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

    initial begin
        bus.enable = 1'b0; bus.restart = 1'b0; bus.throttle = 1'b0; bus.shift_tick = 1'b0;
        reset = 1'b0;
        for (int g = 0; g < 8; g++) begin
            lut_gear = GEAR_W'(g);
            #1;
            check($sformatf("lut_g%0d", g), int'(lut_rate), rate_tab[g], 1'b0);
        end
        ticks(3);
        cmp_on = 1'b1;
        check_start("reset");

        // Test 1: full throttle from the start state.
        reset = 1'b1; bus.enable = 1'b1; bus.throttle = 1'b1;
        ticks(13);
        check("t1_rpm13", int'(bus.rpm), 6200, 1'b0);
        check("t1_gcs13", int'(bus.gear_change_status), 1, 1'b0);
        ticks(5);
        check("t1_rpm18", int'(bus.rpm), 8000, 1'b0);
        check("t1_lim18", int'(bus.limiter_active), 1, 1'b0);

`ifdef AUTO_SHIFT_EN
        // Test 6: gear climbs on its own while throttle is held.
        pulse_restart();
        for (int i = 0; i < 400 && int'(bus.current_gear) != 5; i++) @(negedge clk);
        check("t6_gear", int'(bus.current_gear), 5, 1'b0);
`else
        // Test 2: accepted upshift at 6200.
        pulse_restart();
        ticks(13);
        pulse_shift();
        check("t2_gear",  int'(bus.current_gear), 2, 1'b0);
        check("t2_rpm",   int'(bus.rpm), 3500, 1'b0);
        check("t2_gcs",   int'(bus.gear_change_status), 0, 1'b0);
        check("t2_speed", int'(bus.speed), 54, 1'b0);

        // Test 3: early shift at 3000; a second shift mid-penalty must not reload it.
        pulse_restart();
        ticks(5);
        check("t3_rpm0", int'(bus.rpm), 3000, 1'b0);
        pulse_shift();
        ticks(10);
        pulse_shift();
        ticks(21);
        check("t3_rpm32",  int'(bus.rpm), 1400, 1'b0);
        check("t3_gear32", int'(bus.current_gear), 1, 1'b0);
        ticks(1);
        check("t3_rpm33",  int'(bus.rpm), 1800, 1'b0);

        // Test 4: shift request in top gear at the limiter is ignored.
        pulse_restart();
        climb_to(5);
        ramp_to_limit();
        check("t4_rpm", int'(bus.rpm), 8000, 1'b0);
        pulse_shift();
        check("t4_gear", int'(bus.current_gear), 5, 1'b0);
        check("t4_rpm2", int'(bus.rpm), 8000, 1'b0);
        check("t4_lim",  int'(bus.limiter_active), 1, 1'b0);

        // Test 5: restart from 7000 in gear 3, then an asynchronous reset mid-ramp.
        pulse_restart();
        climb_to(3);
        ramp_to_limit();
        bus.throttle = 1'b0;
        ticks(20);
        check("t5_rpm",   int'(bus.rpm), 7000, 1'b0);
        check("t5_gear",  int'(bus.current_gear), 3, 1'b0);
        check("t5_speed", int'(bus.speed), 162, 1'b0);
        bus.enable = 1'b0;
        ticks(4);
        check("t5_idle_rpm", int'(bus.rpm), 6800, 1'b0);
        bus.enable = 1'b1;
        pulse_restart();
        check_start("restart");
        bus.throttle = 1'b1;
        ticks(6);
        check("t5_ramp", int'(bus.rpm), 3400, 1'b0);
        #2 reset = 1'b0;
        #1 check_start("async_reset");
        @(negedge clk);
        reset = 1'b1;
        ticks(3);
        check("t5_after_reset", int'(bus.rpm), 2200, 1'b0);
`endif

        cmp_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
